// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, GF(2^8) constant, xtime helper and FSM states
package aes_pkg;

  typedef logic [3:0][7:0] col_t;
  typedef logic [127:0]    state_t;

  localparam logic [7:0] GF_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  // Multiply by x in GF(2^8): shift left, fold the dropped bit 7 back via the polynomial
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mix_one_column.sv
// rtl/inv_mix_one_column.sv - combinational InvMixColumns of a single 4-byte column
module inv_mix_one_column
  import aes_pkg::*;
(
  input  col_t col_in,
  output col_t col_out
);

  // Constant multiplies built from x, x^2, x^3 chains
  function automatic logic [7:0] mul9(input logic [7:0] b);
    logic [7:0] x3;
    x3 = xtime(xtime(xtime(b)));
    return x3 ^ b;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] b);
    logic [7:0] x1, x3;
    x1 = xtime(b);
    x3 = xtime(xtime(x1));
    return x3 ^ x1 ^ b;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] b);
    logic [7:0] x2, x3;
    x2 = xtime(xtime(b));
    x3 = xtime(x2);
    return x3 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] b);
    logic [7:0] x1, x2, x3;
    x1 = xtime(b);
    x2 = xtime(x1);
    x3 = xtime(x2);
    return x3 ^ x2 ^ x1;
  endfunction

  logic [7:0] a0, a1, a2, a3;

  // Row 0 is the most significant byte of the column
  always_comb begin
    a0 = col_in[3];
    a1 = col_in[2];
    a2 = col_in[1];
    a3 = col_in[0];
    col_out[3] = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
    col_out[2] = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
    col_out[1] = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
    col_out[0] = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
  end

endmodule

// File: rtl/inv_mix_columns_iter.sv
// rtl/inv_mix_columns_iter.sv - iterative InvMixColumns, one column per cycle
module inv_mix_columns_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  fsm_state_t fsm_q, fsm_d;
  logic [1:0] col_cnt;
  state_t     data_q;
  col_t       cur_col;
  col_t       mixed_col;

  // Column c lives at data_q[127-32c -: 32]
  always_comb begin
    cur_col = data_q[127:96];
    case (col_cnt)
      2'd0: cur_col = data_q[127:96];
      2'd1: cur_col = data_q[95:64];
      2'd2: cur_col = data_q[63:32];
      2'd3: cur_col = data_q[31:0];
      default: cur_col = data_q[127:96];
    endcase
  end

  inv_mix_one_column u_col (
    .col_in  (cur_col),
    .col_out (mixed_col)
  );

  // Next-state logic: accept in IDLE, four column steps in BUSY, hold in DONE until taken
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE: if (in_valid) fsm_d = BUSY;
      BUSY: if (col_cnt == 2'd3) fsm_d = DONE;
      DONE: if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // FSM state and column counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      col_cnt <= 2'd0;
    end else begin
      fsm_q <= fsm_d;
      if (fsm_q == IDLE) begin
        col_cnt <= 2'd0;
      end else if (fsm_q == BUSY) begin
        col_cnt <= col_cnt + 2'd1;
      end
    end
  end

  // State register: latch on accept, overwrite the current column while BUSY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (fsm_q == IDLE && in_valid) begin
      data_q <= in_state;
    end else if (fsm_q == BUSY) begin
      case (col_cnt)
        2'd0: data_q[127:96] <= mixed_col;
        2'd1: data_q[95:64]  <= mixed_col;
        2'd2: data_q[63:32]  <= mixed_col;
        2'd3: data_q[31:0]   <= mixed_col;
        default: data_q[127:96] <= mixed_col;
      endcase
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q != IDLE);
  assign out_state = data_q;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// tb/tb_inv_mix_columns_iter.sv - randomized self-checking bench for inv_mix_columns_iter
module tb_inv_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int tests_run = 0;
  int tests_failed = 0;

  inv_mix_columns_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // General GF(2^8) multiply (shift-and-add, reduce by 0x11B)
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // Circulant matrix product on every column; inverse selects {0e 0b 0d 09}, else {02 03 01 01}
  function automatic logic [127:0] mix_model(input logic [127:0] s, input bit inverse);
    logic [7:0] coef[4];
    logic [7:0] col[4];
    logic [7:0] acc;
    logic [127:0] r = '0;
    if (inverse) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else         coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) col[k] = s[127 - 32*c - 8*k -: 8];
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc ^= gmul(coef[(k - row) & 3], col[k]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Push one block through; entered and left at posedge+1
  task automatic send(input logic [127:0] s, input int hold, input bit junk,
                      output logic [127:0] res);
    int cnt;
    logic [127:0] first;
    in_state = s;
    in_valid = 1'b1;
    out_ready = 1'b0;
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    check_eq("in_ready_before_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid  = junk;
    in_state  = junk ? rand128() : s;
    out_ready = (hold == 0);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    check_eq("latency", cnt, 4);
    in_valid = 1'b0;
    res = out_state;
    first = out_state;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check_eq("bp_out_valid", out_valid, 1);
        check_eq("bp_out_state", out_state, first);
        check_eq("bp_in_ready", in_ready, 0);
        check_eq("bp_busy", busy, 1);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("in_ready_after_handshake", in_ready, 1);
    check_eq("out_valid_after_handshake", out_valid, 0);
  endtask

  logic [127:0] res, orig, v;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_state = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_in_ready", in_ready, 1);
    check_eq("reset_out_valid", out_valid, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_out_state", out_state, 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(128'h8e4da1bc_00000000_00000000_00000000, 0, 1'b0, res);
    check_eq("single_column", res, 128'hdb135345_00000000_00000000_00000000);

    send(128'h046681e5e0cb199a48f8d37a2806264c, 0, 1'b0, res);
    check_eq("full_state", res, 128'hd4bf5d30e0b452aeb84111f11e2798e5);

    send({16{8'h01}}, 0, 1'b0, res);
    check_eq("fixed_01", res, {16{8'h01}});
    send({16{8'hc6}}, 0, 1'b0, res);
    check_eq("fixed_c6", res, {16{8'hc6}});

    v = rand128();
    send(v, 10, 1'b1, res);
    check_eq("backpressure_result", res, mix_model(v, 1'b1));

    // Reset after two columns have been processed, sampled without a clock edge
    in_state = rand128();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    check_eq("midop_reset_out_valid", out_valid, 0);
    check_eq("midop_reset_busy", busy, 0);
    check_eq("midop_reset_in_ready", in_ready, 1);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    v = rand128();
    send(v, 0, 1'b0, res);
    check_eq("after_reset_block", res, mix_model(v, 1'b1));

    for (int i = 0; i < 100; i++) begin
      orig = rand128();
      send(mix_model(orig, 1'b0), (i % 7 == 3) ? 2 : 0, i[0], res);
      check_eq("round_trip", res, orig);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/inv_mix_columns_iter.md
INV_MIX_COLUMNS_ITER -- requirements
Module: inv_mix_columns_iter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port in_valid, input, 1 bit: in_state is valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block accepts a new state.
REQ-005 SHALL have port in_state, input, 128 bits: AES state, FIPS-197 byte order.
REQ-006 SHALL have port out_valid, output, 1 bit: out_state holds a result.
REQ-007 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-008 SHALL have port out_state, output, 128 bits: InvMixColumns(in_state).
REQ-009 SHALL have port busy, output, 1 bit: high in BUSY and DONE.

Function
REQ-010 SHALL map bytes as follows: column c = in_state[127-32c -: 32]; row 0 is the most significant byte of each column.
REQ-011 SHALL compute each output column with matrix rows {0e 0b 0d 09}, {09 0e 0b 0d}, {0d 09 0e 0b}, {0b 0d 09 0e} over GF(2^8), polynomial 0x11B.
REQ-012 SHALL build all GF(2^8) constant multiplies from xtime chains: 8-bit operands, XOR addition, no carries beyond bit 7.
REQ-013 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-014 SHALL use the IDLE->BUSY transition: in IDLE, in_ready=1; on in_valid&&in_ready, latch in_state into the state register and set col_cnt=0.
REQ-015 SHALL operate BUSY as follows: each cycle, replace column col_cnt with its inverse-mixed value and increment col_cnt (2 bits); when col_cnt==3, go to DONE.
REQ-016 SHALL operate DONE as follows: out_valid=1; out_state and busy are held stable until out_valid&&out_ready, then the FSM returns to IDLE.
REQ-017 SHALL have a latency of exactly 4 cycles: out_valid rises on the 4th rising edge after the accepting edge.
REQ-018 SHALL keep in_ready=0 in BUSY and DONE; in_valid is ignored there.
REQ-019 SHALL NOT accept new input in the same cycle as an out_ready handshake; in_ready returns on the cycle after the FSM reaches IDLE (minimum 6 cycles per block).
REQ-020 SHALL ignore out_ready outside DONE.
REQ-021 SHALL use col_cnt wrap-around 3->0 only on the BUSY->DONE transition; col_cnt is don't-care outside BUSY.
REQ-022 SHALL drive out_state directly from the state register; its value outside DONE is unspecified to consumers.

Reset
REQ-023 SHALL, while rst_n=0 and independent of clk, set the FSM to IDLE, col_cnt to 0, the state register to 128'h0, out_valid to 0 and busy to 0.
REQ-024 SHALL assert in_ready=1 immediately after reset.
REQ-025 SHALL abort any in-flight BUSY or DONE operation on reset mid-operation with no output handshake; the pending result is lost.

Structure
REQ-026 SHALL place the following in shared package aes_pkg: the col_t typedef ([3:0][7:0]); the state_t typedef (128 bits); the GF polynomial constant 8'h1B; the xtime function; and the FSM state enum.
REQ-027 SHALL contain exactly one combinational sub-module, inv_mix_one_column (col_t in -> col_t out), instantiated once and muxed by col_cnt.

Verification
REQ-028 SHALL include this single-column scenario: in_state column 0 = 8e 4d a1 bc, other columns 0 -> out_state column 0 = db 13 53 45, other columns 0, with out_valid 4 cycles after accept.
REQ-029 SHALL include this full-state scenario: 046681e5e0cb199a48f8d37a2806264c -> d4bf5d30e0b452aeb84111f11e2798e5.
REQ-030 SHALL include this fixed-point scenario: all bytes 01, then all bytes c6 -> output equals input.
REQ-031 SHALL include this backpressure scenario: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_state stable, in_ready=0; release -> IDLE the next cycle, in_ready=1.
REQ-032 SHALL include this reset scenario: assert rst_n=0 in BUSY after 2 columns -> out_valid=0, busy=0, in_ready=1 without a clock edge; the next block processes correctly.
REQ-033 SHALL include this round-trip scenario: 100 random states through the mixColumns model then this block -> each output equals its original state.
